batcharger_meas_filter: RTL

Digital measurement front-end that sits directly upstream of the battery-charger control FSM (tc/cc/cv sequencing). Accepts a time-multiplexed 10-bit ADC stream carrying battery voltage, battery current and temperature-sense codes. Box-car averages each channel over a power-of-two window and compares the averages against charger thresholds. Presents registered averages and qualified decision flags that the charger FSM uses for its mode transitions.

---
 rtl/batcharger_pkg.sv | 29 ++
 rtl/batcharger_meas_filter_if.sv | 11 +
 rtl/batcharger_avg_acc.sv | 51 +++++
 rtl/batcharger_meas_filter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/batcharger_pkg.sv
// Shared constants, channel encoding and flag reset values for the battery-charger
// measurement front-end.
package batcharger_pkg;

  localparam int unsigned ADC_W = 10;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned DEB_W = 4;

  typedef enum logic [CH_W-1:0] {
    CH_VBAT    = 2'd0,
    CH_IBAT    = 2'd1,
    CH_VTEMP   = 2'd2,
    CH_ILLEGAL = 2'd3
  } ch_e;

  typedef struct packed {
    logic vbat_lt_cutoff;
    logic vbat_ge_float;
    logic ibat_le_iend;
  } chg_flags_t;

  // Safe state: request trickle charge until vbat has actually been measured.
  localparam chg_flags_t FLAGS_RST = '{vbat_lt_cutoff: 1'b1,
                                       vbat_ge_float:  1'b0,
                                       ibat_le_iend:   1'b0};
  localparam logic TEMP_OK_RST = 1'b0;

endpackage

// File: rtl/batcharger_meas_filter_if.sv
// Time-multiplexed ADC sample stream (no backpressure) into the measurement filter.
interface batcharger_meas_filter_if #(
  parameter int unsigned ADC_W = batcharger_pkg::ADC_W
);
  logic                              adc_valid;
  logic [batcharger_pkg::CH_W-1:0]   adc_ch;
  logic [ADC_W-1:0]                  adc_data;

  modport master (output adc_valid, adc_ch, adc_data);
  modport slave  (input  adc_valid, adc_ch, adc_data);
endinterface

// File: rtl/batcharger_avg_acc.sv
// One box-car averaging channel: accumulator, sample counter and registered average.
module batcharger_avg_acc #(
  parameter int unsigned ADC_W    = 10,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             smp_vld,
  input  logic [ADC_W-1:0] smp_data,
  output logic [ADC_W-1:0] avg,
  output logic             upd,
  output logic [ADC_W-1:0] avg_c,
  output logic             done_c
);

  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt;

  // Window sum cannot overflow ACC_W: 2^AVG_LOG2 samples of at most 2^ADC_W-1.
  always_comb begin
    sum_c  = acc + ACC_W'(smp_data);
    done_c = smp_vld && (cnt == LAST_CNT);
    avg_c  = ADC_W'(sum_c >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc <= '0;
      cnt <= '0;
      avg <= '0;
      upd <= 1'b0;
    end else begin
      upd <= done_c;
      if (done_c) begin
        acc <= '0;
        cnt <= '0;
        avg <= avg_c;
      end else if (smp_vld) begin
        acc <= sum_c;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/batcharger_meas_filter.sv
// Measurement front-end for the charger FSM: per-channel box-car averages and threshold flags.
// Optional feature macro: BATCHARGER_TEMP_DEBOUNCE_EN (debounced temp_ok).
module batcharger_meas_filter #(
  parameter int unsigned ADC_W    = batcharger_pkg::ADC_W,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TEMP_DEB = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  batcharger_meas_filter_if.slave   adc,
  input  logic [ADC_W-1:0]          vcutoff_th,
  input  logic [ADC_W-1:0]          vfloat_th,
  input  logic [ADC_W-1:0]          iend_th,
  input  logic [ADC_W-1:0]          tmin_th,
  input  logic [ADC_W-1:0]          tmax_th,
  output logic [ADC_W-1:0]          vbat_avg,
  output logic [ADC_W-1:0]          ibat_avg,
  output logic [ADC_W-1:0]          vtemp_avg,
  output logic [2:0]                avg_upd,
  output logic                      vbat_lt_cutoff,
  output logic                      vbat_ge_float,
  output logic                      ibat_le_iend,
  output logic                      temp_ok,
  output logic                      meas_ready,
  output logic                      ch_err
);

  import batcharger_pkg::*;

  if (AVG_LOG2 < 1 || AVG_LOG2 > 6) begin : g_bad_avg
    $error("AVG_LOG2 out of range 1..6");
  end
  if (TEMP_DEB < 1 || TEMP_DEB > 15) begin : g_bad_deb
    $error("TEMP_DEB out of range 1..15");
  end

  ch_e              ch_c;
  logic [N_CH-1:0]  smp_vld_c;
  logic [N_CH-1:0]  done_c;
  logic [ADC_W-1:0] vbat_avg_c;
  logic [ADC_W-1:0] ibat_avg_c;
  logic [ADC_W-1:0] vtemp_avg_c;
  logic             temp_pass_c;
  logic [N_CH-1:0]  seen_q;
  chg_flags_t       flags_q;

  // Route each strobe to its channel; the illegal tag reaches no accumulator.
  always_comb begin
    ch_c      = ch_e'(adc.adc_ch);
    smp_vld_c = '0;
    if (adc.adc_valid) begin
      case (ch_c)
        CH_VBAT:  smp_vld_c[0] = 1'b1;
        CH_IBAT:  smp_vld_c[1] = 1'b1;
        CH_VTEMP: smp_vld_c[2] = 1'b1;
        default:  smp_vld_c    = '0;
      endcase
    end
    temp_pass_c = (vtemp_avg_c >= tmin_th) && (vtemp_avg_c <= tmax_th);
  end

  batcharger_avg_acc #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_vbat (
    .clk(clk), .rst(rst), .en(en),
    .smp_vld(smp_vld_c[0]), .smp_data(adc.adc_data),
    .avg(vbat_avg), .upd(avg_upd[0]), .avg_c(vbat_avg_c), .done_c(done_c[0])
  );

  batcharger_avg_acc #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_ibat (
    .clk(clk), .rst(rst), .en(en),
    .smp_vld(smp_vld_c[1]), .smp_data(adc.adc_data),
    .avg(ibat_avg), .upd(avg_upd[1]), .avg_c(ibat_avg_c), .done_c(done_c[1])
  );

  batcharger_avg_acc #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_vtemp (
    .clk(clk), .rst(rst), .en(en),
    .smp_vld(smp_vld_c[2]), .smp_data(adc.adc_data),
    .avg(vtemp_avg), .upd(avg_upd[2]), .avg_c(vtemp_avg_c), .done_c(done_c[2])
  );

  // Flags are evaluated from the closing average in the same edge it is registered.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      flags_q    <= FLAGS_RST;
      seen_q     <= '0;
      meas_ready <= 1'b0;
      ch_err     <= 1'b0;
    end else begin
      ch_err     <= adc.adc_valid && (ch_c == CH_ILLEGAL);
      seen_q     <= seen_q | done_c;
      meas_ready <= &(seen_q | done_c);
      if (done_c[0]) begin
        flags_q.vbat_lt_cutoff <= vbat_avg_c <  vcutoff_th;
        flags_q.vbat_ge_float  <= vbat_avg_c >= vfloat_th;
      end
      if (done_c[1]) begin
        flags_q.ibat_le_iend <= ibat_avg_c <= iend_th;
      end
    end
  end

  assign vbat_lt_cutoff = flags_q.vbat_lt_cutoff;
  assign vbat_ge_float  = flags_q.vbat_ge_float;
  assign ibat_le_iend   = flags_q.ibat_le_iend;

`ifdef BATCHARGER_TEMP_DEBOUNCE_EN
  logic [DEB_W-1:0] deb_cnt;

  // temp_ok flips only after TEMP_DEB consecutive disagreeing vtemp windows.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      temp_ok <= TEMP_OK_RST;
      deb_cnt <= '0;
    end else if (done_c[2]) begin
      if (temp_pass_c != temp_ok) begin
        if (deb_cnt == DEB_W'(TEMP_DEB - 1)) begin
          temp_ok <= temp_pass_c;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      temp_ok <= TEMP_OK_RST;
    end else if (done_c[2]) begin
      temp_ok <= temp_pass_c;
    end
  end
`endif

endmodule
